// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
// Imported by imem_load_ctrl and available to anything that instantiates it.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // MOV R0, R0: harmless filler returned whenever the core must not see real memory.
  localparam logic [31:0] NOP_INSTR     = 32'hE1A00000;
  localparam int          DEPTH_DEFAULT = 101;
  localparam int          AW_DEFAULT    = 7;

endpackage : imem_ctrl_pkg

// File: rtl/imem_load_ctrl.sv
// Owns the single instruction-memory port: a loader writes a program in LOAD,
// the fetch stage reads it in RUN, and the core is held stalled otherwise.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          DEPTH = DEPTH_DEFAULT,
  parameter int          AW    = AW_DEFAULT,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  output logic          ld_ready,
  input  logic          run_start,
  input  logic [31:0]   fetch_a,
  output logic [31:0]   fetch_rd,
  output logic          cpu_stall,
  output logic          fetch_fault,
  output logic [31:0]   mem_a,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  input  logic [31:0]   mem_rd,
  output logic          load_done,
  output logic          load_err,
  output logic [AW-1:0] ld_cnt
);

  localparam logic [AW-1:0] DEPTH_AW   = AW'(DEPTH);
  localparam logic [29:0]   DEPTH_WORD = 30'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic          loaded_q, loaded_d;
  logic          load_err_q, load_err_d;
  logic          load_done_q, load_done_d;

  logic len_ok;
  logic wr_fire;
  logic last_wr;
  logic addr_bad;

  assign len_ok   = (ld_len != '0) && (ld_len <= DEPTH_AW);
  assign wr_fire  = (state_q == ST_LOAD) && ld_valid;
  assign last_wr  = wr_fire && (cnt_q == len_q - AW'(1));
  assign addr_bad = (fetch_a[1:0] != 2'b00) || (fetch_a[31:2] >= DEPTH_WORD);

  // Next-state logic. LOAD ignores both requests; HALT and RUN share the
  // load_start handling, and load_start always takes precedence over run_start.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    loaded_d    = loaded_q;
    load_err_d  = load_err_q;
    load_done_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (wr_fire) begin
          cnt_d = cnt_q + AW'(1);
          if (last_wr) begin
            state_d     = ST_HALT;
            loaded_d    = 1'b1;
            load_done_d = 1'b1;
          end
        end
      end
      ST_HALT, ST_RUN: begin
        if (load_start) begin
          if (len_ok) begin
            state_d    = ST_LOAD;
            len_d      = ld_len;
            cnt_d      = '0;
            load_err_d = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (run_start && (state_q == ST_HALT) && loaded_q) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Memory port and core-facing outputs decode directly from state so a RUN
  // fetch completes in the same cycle it is presented.
  always_comb begin
    ld_ready    = 1'b0;
    cpu_stall   = 1'b1;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    fetch_rd    = NOP;
    fetch_fault = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we = 1'b1;
          mem_a  = {{(30 - AW){1'b0}}, cnt_q, 2'b00};
          mem_wd = ld_data;
        end
      end
      ST_RUN: begin
        cpu_stall   = 1'b0;
        mem_a       = fetch_a;
        fetch_fault = addr_bad;
        fetch_rd    = addr_bad ? NOP : mem_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HALT;
      cnt_q       <= '0;
      len_q       <= '0;
      loaded_q    <= 1'b0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      loaded_q    <= loaded_d;
      load_err_q  <= load_err_d;
      load_done_q <= load_done_d;
    end
  end

  assign ld_cnt    = cnt_q;
  assign load_err  = load_err_q;
  assign load_done = load_done_q;

endmodule : imem_load_ctrl

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: the driver pushes predicted per-cycle
// status and memory writes, a negedge monitor pops and compares them.
module tb_imem_load_ctrl;

  localparam int          DEPTH = 101;
  localparam logic [31:0] NOP   = 32'hE1A00000;
  localparam int M_HALT = 0, M_LOAD = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0, run_start = 1'b0, ld_valid = 1'b0;
  logic [6:0]  ld_len = '0;
  logic [31:0] ld_data = '0, fetch_a = '0;
  logic        ld_ready, cpu_stall, fetch_fault, mem_we, load_done, load_err;
  logic [31:0] fetch_rd, mem_a, mem_wd, mem_rd;
  logic [6:0]  ld_cnt;

  imem_load_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .run_start(run_start), .fetch_a(fetch_a), .fetch_rd(fetch_rd),
    .cpu_stall(cpu_stall), .fetch_fault(fetch_fault), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .load_done(load_done),
    .load_err(load_err), .ld_cnt(ld_cnt)
  );

  always #5 clk = ~clk;

  // External instruction memory: combinational read, write on the rising edge.
  logic [31:0] mem [DEPTH];
  assign mem_rd = (mem_a[31:2] < 30'(DEPTH)) ? mem[mem_a[8:2]] : 32'hDEADBEEF;
  always @(posedge clk) if (mem_we && mem_a[31:2] < 30'(DEPTH)) mem[mem_a[8:2]] = mem_wd;

  typedef struct {
    logic        stall, ready, we, fault, err, done;
    logic [31:0] rd;
    logic [6:0]  cnt;
  } status_t;
  typedef struct { logic [31:0] a, d; } wr_t;

  status_t st_q[$];
  wr_t     wr_q[$];
  int n_tests = 0, n_fail = 0;

  // Reference model: mode, program length/progress and the expected memory image.
  int          m_mode, m_len, m_cnt;
  bit          m_loaded, m_err, m_done;
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    status_t s;
    wr_t     w;
    if (reset) begin
      if (st_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL status_underflow at %0t: got none expected one", $time);
      end else begin
        s = st_q.pop_front();
        check("cpu_stall",   32'(cpu_stall),   32'(s.stall));
        check("ld_ready",    32'(ld_ready),    32'(s.ready));
        check("mem_we",      32'(mem_we),      32'(s.we));
        check("fetch_fault", 32'(fetch_fault), 32'(s.fault));
        check("load_err",    32'(load_err),    32'(s.err));
        check("load_done",   32'(load_done),   32'(s.done));
        check("ld_cnt",      32'(ld_cnt),      32'(s.cnt));
        check("fetch_rd",    fetch_rd,         s.rd);
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write at %0t: got a=%h expected none", $time, mem_a);
        end else begin
          w = wr_q.pop_front();
          check("write_addr", mem_a,  w.a);
          check("write_data", mem_wd, w.d);
        end
      end
    end
  end

  task automatic model_reset();
    m_mode = M_HALT; m_len = 0; m_cnt = 0;
    m_loaded = 0; m_err = 0; m_done = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    load_start = 0; run_start = 0; ld_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input bit ls, input int len, input bit rs, input bit lv,
                      input logic [31:0] ld, input logic [31:0] fa);
    status_t s;
    bit      bad;
    bit      nd;
    @(posedge clk); #1;
    load_start = ls; ld_len = 7'(len); run_start = rs;
    ld_valid = lv; ld_data = ld; fetch_a = fa;
    bad = (fa % 4 != 0) || (fa / 4 >= DEPTH);
    s.stall = (m_mode != M_RUN);
    s.ready = (m_mode == M_LOAD);
    s.we    = (m_mode == M_LOAD) && lv;
    s.fault = (m_mode == M_RUN) && bad;
    s.rd    = (m_mode == M_RUN && !bad) ? ref_mem[int'(fa >> 2)] : NOP;
    s.err   = m_err;
    s.done  = m_done;
    s.cnt   = 7'(m_cnt);
    st_q.push_back(s);
    if (s.we) wr_q.push_back('{a: 32'(m_cnt * 4), d: ld});
    nd = 0;
    if (m_mode == M_LOAD) begin
      if (lv) begin
        ref_mem[m_cnt] = ld;
        m_cnt++;
        if (m_cnt == m_len) begin
          m_mode = M_HALT; m_loaded = 1; nd = 1;
        end
      end
    end else if (ls) begin
      if (len >= 1 && len <= DEPTH) begin
        m_mode = M_LOAD; m_len = len; m_cnt = 0; m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (rs && m_mode == M_HALT && m_loaded) begin
      m_mode = M_RUN;
    end
    m_done = nd;
  endtask

  task automatic idle(input logic [31:0] fa);
    step(0, 0, 0, 0, 32'h0, fa);
  endtask

  initial begin
    logic [31:0] prog [3];
    int          len;
    prog[0] = 32'hE3A01007; prog[1] = 32'hE3A02002; prog[2] = 32'hE1A03231;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    do_reset();

    // Run request without any completed load must be ignored.
    idle(0);
    step(0, 0, 1, 0, 0, 0);
    idle(0);
    @(negedge clk);
    check("stall_without_program", 32'(cpu_stall), 32'd1);
    check("nop_without_program", fetch_rd, NOP);

    // Three-word load with continuous ld_valid, then release and fetch.
    step(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, prog[i], 0);
    idle(0);
    @(negedge clk);
    check("load_done_pulse", 32'(load_done), 32'd1);
    check("ld_cnt_three", 32'(ld_cnt), 32'd3);
    idle(0);
    step(0, 0, 1, 0, 0, 8);
    step(0, 0, 0, 0, 0, 8);
    @(negedge clk);
    check("fetch_word2", fetch_rd, 32'hE1A03231);
    idle(404);
    idle(6);
    idle(4);

    // Rejected lengths in RUN keep running; a valid one clears load_err.
    step(1, 0, 0, 0, 0, 0);
    idle(0);
    step(1, 102, 0, 0, 0, 4);
    idle(4);
    @(negedge clk);
    check("load_err_sticky", 32'(load_err), 32'd1);
    step(1, 2, 1, 0, 0, 0);
    step(0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, $urandom, 0);
    step(0, 0, 0, 1, $urandom, 0);
    idle(0);
    step(1, 127, 0, 0, 0, 0);
    idle(0);

    // Full-depth load; the last word is reachable, one past it faults.
    step(1, DEPTH, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 1, $urandom, 0);
    idle(0);
    step(0, 0, 1, 0, 0, 400);
    idle(400);
    idle(404);
    idle(32'hFFFF_FFFC);

    // Reset two words into a five-word load: loaded flag is lost.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 1, $urandom, 0);
    do_reset();
    idle(0);
    @(negedge clk);
    check("ld_cnt_after_abort", 32'(ld_cnt), 32'd0);
    step(0, 0, 1, 0, 0, 0);
    idle(0);
    @(negedge clk);
    check("run_ignored_after_abort", 32'(cpu_stall), 32'd1);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      bit          ls, rs, lv;
      logic [31:0] fa;
      ls  = ($urandom_range(0, 99) < 6);
      rs  = ($urandom_range(0, 99) < 10);
      lv  = ($urandom_range(0, 99) < 75);
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                        : int'($urandom_range(1, 8));
      fa  = ($urandom_range(0, 9) < 7) ? {$urandom_range(0, DEPTH - 1), 2'b00}
                                       : $urandom;
      if ($urandom_range(0, 299) == 0) do_reset();
      step(ls, len, rs, lv, $urandom, fa);
    end

    idle(0);
    @(negedge clk); #1;
    check("status_queue_drained", st_q.size(), 32'd0);
    check("write_queue_drained", wr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_load_ctrl
